cla_share_arb: RTL and testbench

- Time-shares one registered 16-bit carry-lookahead adder (ports A, B, S, C16, Clk, Rst) between two independent requesters.
- Per cycle: arbitrates round-robin, drives the winner's operands onto the adder, and tags the issue with the requester ID.
- Routes the adder's sum and carry-out back to the correct requester after a fixed latency.
- Sits between the datapath clients and the shared adder instance.

---
 rtl/cla_share_arb.sv | 147 ++++++++++++++
 tb/tb_cla_share_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cla_share_arb
//  Purpose  : Round-robin time-sharing of one registered carry-lookahead
//             adder between two requesters. Winner operands go to the adder,
//             an {valid,id} tag follows the adder latency, and the result is
//             steered back to the requester that issued it.
//  Revision : 1.0  initial release
// ============================================================================
module cla_share_arb #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 1      // adder latency in clock edges, 1..4
) (
    input  logic             Clk,
    input  logic             Rst,          // asynchronous, active-low

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c,

    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,

    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout,

    output logic             busy
);

    // Priority pointer: 0 favours requester 0, 1 favours requester 1.
    logic               prio_q, prio_d;
    logic               grant0, grant1, issue;

    // Tag pipeline: index 0 is the newest entry, ADD_LAT-1 lines up with add_s.
    logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ADD_LAT-1:0] tag_id_q,  tag_id_d;
    logic               end_vld, end_id;

    logic               rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0]   rsp0_sum_q,   rsp0_sum_d;
    logic               rsp0_cout_q,  rsp0_cout_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0]   rsp1_sum_q,   rsp1_sum_d;
    logic               rsp1_cout_q,  rsp1_cout_d;

    // Grant: a lone requester always wins; contention is settled by the pointer,
    // which then points at the loser so it wins the very next contended cycle.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio_q);
        grant1 = req1_valid && (!req0_valid ||  prio_q);
        issue  = grant0 || grant1;
        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    // Operand steering; idle cycles present zeros to the adder.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (grant0) begin
            add_a = req0_a;
            add_b = req0_b;
        end else if (grant1) begin
            add_a = req1_a;
            add_b = req1_b;
        end
    end

    // Tag shift: new issue enters at stage 0, older entries move one stage on.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = grant1;
        for (int i = 1; i < ADD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    assign end_vld = tag_vld_q[ADD_LAT-1];
    assign end_id  = tag_id_q[ADD_LAT-1];

    // Response steering: only the tagged requester captures; the other keeps data.
    always_comb begin
        rsp0_valid_d = end_vld && !end_id;
        rsp1_valid_d = end_vld &&  end_id;
        rsp0_sum_d   = rsp0_valid_d ? add_s : rsp0_sum_q;
        rsp0_cout_d  = rsp0_valid_d ? add_c : rsp0_cout_q;
        rsp1_sum_d   = rsp1_valid_d ? add_s : rsp1_sum_q;
        rsp1_cout_d  = rsp1_valid_d ? add_c : rsp1_cout_q;
    end

    // State registers; reset discards in-flight tags so they never respond.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prio_q       <= 1'b0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_sum_q   <= '0;
            rsp0_cout_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_sum_q   <= '0;
            rsp1_cout_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_sum_q   <= rsp0_sum_d;
            rsp0_cout_q  <= rsp0_cout_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_sum_q   <= rsp1_sum_d;
            rsp1_cout_q  <= rsp1_cout_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_sum   = rsp0_sum_q;
    assign rsp0_cout  = rsp0_cout_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_sum   = rsp1_sum_q;
    assign rsp1_cout  = rsp1_cout_q;
    assign busy       = (|tag_vld_q) || rsp0_valid_q || rsp1_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_share_arb
//  Purpose  : Directed bench for cla_share_arb with ADD_LAT=1 and ADD_LAT=3
//             instances, each driving its own registered adder model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_share_arb;

    localparam int WIDTH = 16;

    logic             Clk;
    logic             Rst;
    logic             r0v, r1v;
    logic [WIDTH-1:0] r0a, r0b, r1a, r1b;

    // Instance with ADD_LAT = 1
    logic             d1_rdy0, d1_rdy1, d1_add_c, d1_busy;
    logic [WIDTH-1:0] d1_add_a, d1_add_b, d1_add_s;
    logic             d1_v0, d1_c0, d1_v1, d1_c1;
    logic [WIDTH-1:0] d1_s0, d1_s1;

    // Instance with ADD_LAT = 3
    logic             d3_rdy0, d3_rdy1, d3_add_c, d3_busy;
    logic [WIDTH-1:0] d3_add_a, d3_add_b, d3_add_s;
    logic             d3_v0, d3_c0, d3_v1, d3_c1;
    logic [WIDTH-1:0] d3_s0, d3_s1;

    int n_vec = 0;
    int n_err = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    cla_share_arb #(.WIDTH(WIDTH), .ADD_LAT(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(r0v), .req0_ready(d1_rdy0), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(d1_rdy1), .req1_a(r1a), .req1_b(r1b),
        .add_a(d1_add_a), .add_b(d1_add_b), .add_s(d1_add_s), .add_c(d1_add_c),
        .rsp0_valid(d1_v0), .rsp0_sum(d1_s0), .rsp0_cout(d1_c0),
        .rsp1_valid(d1_v1), .rsp1_sum(d1_s1), .rsp1_cout(d1_c1),
        .busy(d1_busy)
    );

    cla_share_arb #(.WIDTH(WIDTH), .ADD_LAT(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(r0v), .req0_ready(d3_rdy0), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(d3_rdy1), .req1_a(r1a), .req1_b(r1b),
        .add_a(d3_add_a), .add_b(d3_add_b), .add_s(d3_add_s), .add_c(d3_add_c),
        .rsp0_valid(d3_v0), .rsp0_sum(d3_s0), .rsp0_cout(d3_c0),
        .rsp1_valid(d3_v1), .rsp1_sum(d3_s1), .rsp1_cout(d3_c1),
        .busy(d3_busy)
    );

    // Registered adder models: one stage and three stages.
    logic [WIDTH:0] a1_q, a3_p1, a3_p2, a3_p3;
    always @(posedge Clk) begin
        a1_q  <= {1'b0, d1_add_a} + {1'b0, d1_add_b};
        a3_p1 <= {1'b0, d3_add_a} + {1'b0, d3_add_b};
        a3_p2 <= a3_p1;
        a3_p3 <= a3_p2;
    end
    assign d1_add_s = a1_q[WIDTH-1:0];
    assign d1_add_c = a1_q[WIDTH];
    assign d3_add_s = a3_p3[WIDTH-1:0];
    assign d3_add_c = a3_p3[WIDTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_pulse();
        Rst = 1'b0;
        next_cycle();
        Rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0;
        r0v = 1'b0; r0a = '0; r0b = '0;
        r1v = 1'b0; r1a = '0; r1b = '0;
        repeat (3) next_cycle();
        check_eq("rst_rsp0_valid", d1_v0, 0);
        check_eq("rst_rsp1_valid", d1_v1, 0);
        check_eq("rst_rsp0_sum",   d1_s0, 0);
        check_eq("rst_rsp1_cout",  d1_c1, 0);
        check_eq("rst_busy1",      d1_busy, 0);
        check_eq("rst_busy3",      d3_busy, 0);
        Rst = 1'b1;

        // Single req0, ADD_LAT=1
        r0v = 1'b1; r0a = 16'h0001; r0b = 16'h0002;
        #1;
        check_eq("t1_ready0", d1_rdy0, 1);
        check_eq("t1_ready1", d1_rdy1, 0);
        check_eq("t1_add_a",  d1_add_a, 16'h0001);
        check_eq("t1_add_b",  d1_add_b, 16'h0002);
        next_cycle();
        r0v = 1'b0; r0a = '0; r0b = '0;
        check_eq("t1_early_v0", d1_v0, 0);
        check_eq("t1_busy_fly", d1_busy, 1);
        next_cycle();
        check_eq("t1_rsp0_valid", d1_v0, 1);
        check_eq("t1_rsp0_sum",   d1_s0, 16'h0003);
        check_eq("t1_rsp0_cout",  d1_c0, 0);
        check_eq("t1_rsp1_valid", d1_v1, 0);
        next_cycle();
        check_eq("t1_pulse_end",  d1_v0, 0);
        check_eq("t1_busy_idle",  d1_busy, 0);
        repeat (4) next_cycle();

        // Contention, ADD_LAT=1: alternating grants starting with req0
        reset_pulse();
        r0v = 1'b1; r0a = 16'hFFFF; r0b = 16'h0001;
        r1v = 1'b1; r1a = 16'h1234; r1b = 16'h0001;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("t2_ready0", d1_rdy0, (k % 2 == 0) ? 1 : 0);
            check_eq("t2_ready1", d1_rdy1, (k % 2 == 1) ? 1 : 0);
            check_eq("t2_add_a",  d1_add_a, (k % 2 == 0) ? 16'hFFFF : 16'h1234);
            if (k == 1) begin
                check_eq("t2_no_rsp0", d1_v0, 0);
                check_eq("t2_no_rsp1", d1_v1, 0);
            end else if (k >= 2) begin
                check_eq("t2_rsp0_valid", d1_v0, (k % 2 == 0) ? 1 : 0);
                check_eq("t2_rsp1_valid", d1_v1, (k % 2 == 1) ? 1 : 0);
                if (k % 2 == 0) begin
                    check_eq("t2_rsp0_sum",  d1_s0, 16'h0000);
                    check_eq("t2_rsp0_cout", d1_c0, 1);
                end else begin
                    check_eq("t2_rsp1_sum",  d1_s1, 16'h1235);
                    check_eq("t2_rsp1_cout", d1_c1, 0);
                end
            end
            next_cycle();
        end
        r0v = 1'b0; r1v = 1'b0;
        repeat (5) next_cycle();

        // ADD_LAT=3, single req1
        reset_pulse();
        r1v = 1'b1; r1a = 16'h8000; r1b = 16'h8000;
        #1;
        check_eq("t3_ready1", d3_rdy1, 1);
        check_eq("t3_add_a",  d3_add_a, 16'h8000);
        next_cycle();
        r1v = 1'b0; r1a = '0; r1b = '0;
        for (int j = 1; j <= 3; j++) begin
            check_eq("t3_busy_fly", d3_busy, 1);
            check_eq("t3_early_v1", d3_v1, 0);
            next_cycle();
        end
        check_eq("t3_rsp1_valid", d3_v1, 1);
        check_eq("t3_rsp1_sum",   d3_s1, 16'h0000);
        check_eq("t3_rsp1_cout",  d3_c1, 1);
        check_eq("t3_rsp0_valid", d3_v0, 0);
        check_eq("t3_busy_rsp",   d3_busy, 1);
        next_cycle();
        check_eq("t3_pulse_end",  d3_v1, 0);
        check_eq("t3_busy_idle",  d3_busy, 0);

        // Reset mid-flight, ADD_LAT=1
        r0v = 1'b1; r0a = 16'h0005; r0b = 16'h0006;
        #1;
        check_eq("t4_ready0", d1_rdy0, 1);
        next_cycle();
        r0v = 1'b0; r0a = '0; r0b = '0;
        Rst = 1'b0;
        #1;
        check_eq("t4_rst_v0",    d1_v0, 0);
        check_eq("t4_rst_busy",  d1_busy, 0);
        check_eq("t4_rst_sum0",  d1_s0, 0);
        check_eq("t4_rst_sum1",  d1_s1, 0);
        check_eq("t4_rst_add_a", d1_add_a, 0);
        check_eq("t4_rst_ready", d1_rdy0, 0);
        next_cycle();
        Rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check_eq("t4_no_rsp0", d1_v0, 0);
            check_eq("t4_no_busy", d1_busy, 0);
            next_cycle();
        end
        r0v = 1'b1; r0a = 16'h0007; r0b = 16'h0008;
        #1;
        check_eq("t4_post_ready0", d1_rdy0, 1);
        next_cycle();
        r0v = 1'b0;
        next_cycle();
        check_eq("t4_post_v0",  d1_v0, 1);
        check_eq("t4_post_sum", d1_s0, 16'h000F);
        repeat (4) next_cycle();

        // Idle, then back-to-back lone req1
        check_eq("t5_idle_add_a", d1_add_a, 0);
        check_eq("t5_idle_add_b", d1_add_b, 0);
        check_eq("t5_idle_busy1", d1_busy, 0);
        check_eq("t5_idle_busy3", d3_busy, 0);
        r1v = 1'b1; r1a = 16'h0001; r1b = 16'h0001;
        #1;
        check_eq("t5_ready1_a", d1_rdy1, 1);
        next_cycle();
        r1a = 16'h0002; r1b = 16'h0003;
        #1;
        check_eq("t5_ready1_b", d1_rdy1, 1);
        check_eq("t5_ready0_b", d1_rdy0, 0);
        check_eq("t5_add_a_b",  d1_add_a, 16'h0002);
        next_cycle();
        r1v = 1'b0; r1a = '0; r1b = '0;
        check_eq("t5_rsp1_v_a", d1_v1, 1);
        check_eq("t5_rsp1_s_a", d1_s1, 16'h0002);
        next_cycle();
        check_eq("t5_rsp1_v_b", d1_v1, 1);
        check_eq("t5_rsp1_s_b", d1_s1, 16'h0005);
        check_eq("t5_busy_b",   d1_busy, 1);
        next_cycle();
        check_eq("t5_rsp1_end", d1_v1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
